// File: rtl/ddr_cmd_ctrl.sv
// ddr_cmd_ctrl: single-outstanding-request DDR command sequencer with per-bank
// open-row tracking and a free-running all-bank refresh scheduler.
// Commands and DQ controls are decoded from registered state, so every output
// is glitch-free and settles to NOP/idle on the edge after reset.
// The wait counters assume tRP, tRCD, tWR, tRFC >= 2 and CL >= 1.
module ddr_cmd_ctrl #(
    parameter int unsigned ROW_WIDTH  = 16,
    parameter int unsigned COL_WIDTH  = 10,
    parameter int unsigned BANK_WIDTH = 3,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned MASK_WIDTH = 8,
    parameter int unsigned tRCD       = 4,
    parameter int unsigned tRP        = 4,
    parameter int unsigned tWR        = 4,
    parameter int unsigned CL         = 3,
    parameter int unsigned tREFI      = 780,
    parameter int unsigned tRFC       = 10
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      req_valid,
    output logic                                      req_ready,
    input  logic                                      req_we,
    input  logic [BANK_WIDTH+ROW_WIDTH+COL_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]                     req_wdata,
    input  logic [MASK_WIDTH-1:0]                     req_wmask,
    output logic                                      rd_valid,
    output logic [DATA_WIDTH-1:0]                     rd_data,
    output logic                                      cs_n,
    output logic                                      ras_n,
    output logic                                      cas_n,
    output logic                                      we_n,
    output logic [BANK_WIDTH-1:0]                     ba,
    output logic [ROW_WIDTH-1:0]                      addr,
    output logic [DATA_WIDTH-1:0]                     dq_o,
    output logic                                      dq_oe,
    input  logic [DATA_WIDTH-1:0]                     dq_i,
    output logic [MASK_WIDTH-1:0]                     dm
);

    localparam int unsigned AddrW    = BANK_WIDTH + ROW_WIDTH + COL_WIDTH;
    localparam int unsigned NumBanks = 1 << BANK_WIDTH;
    localparam int unsigned CntW     = 16;
    localparam int unsigned RefW     = $clog2(tREFI);

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CmdNop   = 4'b0111;
    localparam logic [3:0] CmdAct   = 4'b0011;
    localparam logic [3:0] CmdRead  = 4'b0101;
    localparam logic [3:0] CmdWrite = 4'b0100;
    localparam logic [3:0] CmdPre   = 4'b0010;
    localparam logic [3:0] CmdRef   = 4'b0001;

    typedef enum logic [3:0] {
        StIdle, StPre, StPreWait, StAct, StActWait,
        StRdWr, StRdWait, StWrRecov, StRef, StRefWait
    } state_e;

    state_e                                state_q, state_d;
    logic [CntW-1:0]                       cnt_q, cnt_d;
    logic                                  ref_mode_q, ref_mode_d;
    logic [BANK_WIDTH-1:0]                 ref_bank_q, ref_bank_d;
    logic                                  req_we_q, req_we_d;
    logic [AddrW-1:0]                      req_addr_q, req_addr_d;
    logic [DATA_WIDTH-1:0]                 req_wdata_q, req_wdata_d;
    logic [MASK_WIDTH-1:0]                 req_wmask_q, req_wmask_d;
    logic [NumBanks-1:0]                   bank_open_q, bank_open_d;
    logic [NumBanks-1:0][ROW_WIDTH-1:0]    open_row_q, open_row_d;
    logic [RefW-1:0]                       ref_cnt_q, ref_cnt_d;
    logic                                  ref_pend_q, ref_pend_d;
    logic                                  wr_beat2_q, wr_beat2_d;
    logic                                  rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0]                 rd_data_q, rd_data_d;

    logic [BANK_WIDTH-1:0] in_bank, req_bank, pre_bank, low_bank;
    logic [ROW_WIDTH-1:0]  in_row, req_row;
    logic [COL_WIDTH-1:0]  req_col;
    logic                  any_open, data_beat;
    logic [3:0]            cmd;

    assign in_bank  = req_addr[AddrW-1 -: BANK_WIDTH];
    assign in_row   = req_addr[COL_WIDTH +: ROW_WIDTH];
    assign req_bank = req_addr_q[AddrW-1 -: BANK_WIDTH];
    assign req_row  = req_addr_q[COL_WIDTH +: ROW_WIDTH];
    assign req_col  = req_addr_q[COL_WIDTH-1:0];
    // Refresh precharges walk the open banks; request precharges hit the request bank.
    assign pre_bank = ref_mode_q ? ref_bank_q : req_bank;

    // Lowest-numbered open bank, used to precharge banks in ascending order.
    always_comb begin
        any_open = 1'b0;
        low_bank = '0;
        for (int i = int'(NumBanks) - 1; i >= 0; i--) begin
            if (bank_open_q[i]) begin
                any_open = 1'b1;
                low_bank = BANK_WIDTH'(i);
            end
        end
    end

    // Free-running refresh interval counter; pending holds until REF is issued.
    always_comb begin
        ref_cnt_d  = ref_cnt_q + 1'b1;
        ref_pend_d = ref_pend_q;
        if (state_q == StRef) ref_pend_d = 1'b0;
        if (ref_cnt_q == RefW'(tREFI - 1)) begin
            ref_cnt_d  = '0;
            ref_pend_d = 1'b1;
        end
    end

    // Main sequencer: next state, request latch, bank table and read capture.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ref_mode_d  = ref_mode_q;
        ref_bank_d  = ref_bank_q;
        req_we_d    = req_we_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        req_wmask_d = req_wmask_q;
        bank_open_d = bank_open_q;
        open_row_d  = open_row_q;
        wr_beat2_d  = 1'b0;
        rd_valid_d  = 1'b0;
        rd_data_d   = rd_data_q;
        unique case (state_q)
            StIdle: begin
                if (ref_pend_q) begin
                    ref_mode_d = 1'b1;
                    if (any_open) begin
                        ref_bank_d = low_bank;
                        state_d    = StPre;
                    end else begin
                        state_d = StRef;
                    end
                end else if (req_valid) begin
                    ref_mode_d  = 1'b0;
                    req_we_d    = req_we;
                    req_addr_d  = req_addr;
                    req_wdata_d = req_wdata;
                    req_wmask_d = req_wmask;
                    if (!bank_open_q[in_bank]) state_d = StAct;
                    else if (open_row_q[in_bank] == in_row) state_d = StRdWr;
                    else state_d = StPre;
                end
            end
            StPre: begin
                bank_open_d[pre_bank] = 1'b0;
                cnt_d   = CntW'(tRP - 2);
                state_d = StPreWait;
            end
            StPreWait: begin
                if (cnt_q == '0) begin
                    if (!ref_mode_q) begin
                        state_d = StAct;
                    end else if (any_open) begin
                        ref_bank_d = low_bank;
                        state_d    = StPre;
                    end else begin
                        state_d = StRef;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StAct: begin
                bank_open_d[req_bank] = 1'b1;
                open_row_d[req_bank]  = req_row;
                cnt_d   = CntW'(tRCD - 2);
                state_d = StActWait;
            end
            StActWait: begin
                if (cnt_q == '0) state_d = StRdWr;
                else cnt_d = cnt_q - 1'b1;
            end
            StRdWr: begin
                if (req_we_q) begin
                    wr_beat2_d = 1'b1;
                    cnt_d      = CntW'(tWR - 2);
                    state_d    = StWrRecov;
                end else begin
                    cnt_d   = CntW'(CL - 1);
                    state_d = StRdWait;
                end
            end
            StRdWait: begin
                if (cnt_q == '0) begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = dq_i;
                    state_d    = StIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StWrRecov: begin
                if (cnt_q == '0) state_d = StIdle;
                else cnt_d = cnt_q - 1'b1;
            end
            StRef: begin
                cnt_d   = CntW'(tRFC - 2);
                state_d = StRefWait;
            end
            StRefWait: begin
                if (cnt_q == '0) begin
                    ref_mode_d = 1'b0;
                    state_d    = StIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Command bus and DQ controls decoded from the current state.
    always_comb begin
        cmd  = CmdNop;
        ba   = '0;
        addr = '0;
        case (state_q)
            StPre: begin
                cmd = CmdPre;
                ba  = pre_bank;
            end
            StAct: begin
                cmd  = CmdAct;
                ba   = req_bank;
                addr = req_row;
            end
            StRdWr: begin
                cmd  = req_we_q ? CmdWrite : CmdRead;
                ba   = req_bank;
                addr = ROW_WIDTH'(req_col);
            end
            StRef: cmd = CmdRef;
            default: ;
        endcase
        // Write data is held for the WRITE cycle and the one after it.
        data_beat = ((state_q == StRdWr) && req_we_q) || wr_beat2_q;
        dq_oe     = data_beat;
        dq_o      = data_beat ? req_wdata_q : '0;
        dm        = data_beat ? ~req_wmask_q : '0;
        req_ready = (state_q == StIdle) && !ref_pend_q && !reset;
    end

    assign {cs_n, ras_n, cas_n, we_n} = cmd;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            ref_mode_q  <= 1'b0;
            ref_bank_q  <= '0;
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_wmask_q <= '0;
            bank_open_q <= '0;
            open_row_q  <= '0;
            ref_cnt_q   <= '0;
            ref_pend_q  <= 1'b0;
            wr_beat2_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ref_mode_q  <= ref_mode_d;
            ref_bank_q  <= ref_bank_d;
            req_we_q    <= req_we_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            req_wmask_q <= req_wmask_d;
            bank_open_q <= bank_open_d;
            open_row_q  <= open_row_d;
            ref_cnt_q   <= ref_cnt_d;
            ref_pend_q  <= ref_pend_d;
            wr_beat2_q  <= wr_beat2_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
        end
    end

endmodule

// File: tb/tb_ddr_cmd_ctrl.sv
// tb_ddr_cmd_ctrl: directed checks of command timing, row hit/miss routing,
// write masking, read return, refresh sequencing and reset abort.
module tb_ddr_cmd_ctrl;

    localparam int CL = 3;
    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_ACT   = 4'b0011;
    localparam logic [3:0] CMD_READ  = 4'b0101;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_PRE   = 4'b0010;
    localparam logic [3:0] CMD_REF   = 4'b0001;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [28:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [7:0]  req_wmask = '0;
    logic        rd_valid;
    logic [63:0] rd_data;
    logic        cs_n, ras_n, cas_n, we_n;
    logic [2:0]  ba;
    logic [15:0] addr;
    logic [63:0] dq_o;
    logic        dq_oe;
    logic [63:0] dq_i = '0;
    logic [7:0]  dm;
    logic [3:0]  cmd_bus;

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;
    int t, at, rc, n_rd, n_rv;

    ddr_cmd_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wmask (req_wmask),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .cs_n      (cs_n),
        .ras_n     (ras_n),
        .cas_n     (cas_n),
        .we_n      (we_n),
        .ba        (ba),
        .addr      (addr),
        .dq_o      (dq_o),
        .dq_oe     (dq_oe),
        .dq_i      (dq_i),
        .dm        (dm)
    );

    assign cmd_bus = {cs_n, ras_n, cas_n, we_n};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model driven purely from the DDR pins.
    logic [7:0][15:0]  mrow = '0;
    logic [63:0]       mem [logic [28:0]];
    logic [28:0]       rd_key = '0;
    int                rd_due = -100;
    always @(negedge clk) begin
        logic [28:0] k;
        logic [63:0] w;
        if (cmd_bus == CMD_ACT) mrow[ba] = addr;
        if (cmd_bus == CMD_WRITE) begin
            k = {ba, mrow[ba], addr[9:0]};
            w = mem.exists(k) ? mem[k] : 64'h0;
            for (int b = 0; b < 8; b++) if (!dm[b]) w[8*b +: 8] = dq_o[8*b +: 8];
            mem[k] = w;
        end
        if (cmd_bus == CMD_READ) begin
            rd_key = {ba, mrow[ba], addr[9:0]};
            rd_due = cyc + CL;
        end
        dq_i = (cyc == rd_due) ? (mem.exists(rd_key) ? mem[rd_key] : 64'h0)
                               : 64'hDEAD_BEEF_DEAD_BEEF;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_cmd(input logic [3:0] c, input int max, output int found);
        int i = 0;
        found = -1;
        while (found < 0 && i <= max) begin
            if (cmd_bus == c) found = cyc;
            else begin
                @(negedge clk);
                i++;
            end
        end
    endtask

    task automatic wait_ready(input int max, output int found);
        int i = 0;
        found = -1;
        while (found < 0 && i <= max) begin
            if (req_ready) found = cyc;
            else begin
                @(negedge clk);
                i++;
            end
        end
    endtask

    task automatic wait_rdv(input int max, output int found);
        int i = 0;
        found = -1;
        while (found < 0 && i <= max) begin
            if (rd_valid) found = cyc;
            else begin
                @(negedge clk);
                i++;
            end
        end
    endtask

    // Offer one request; returns the cycle in which its first command is driven.
    task automatic issue(input logic we, input logic [2:0] bk, input logic [15:0] row,
                         input logic [9:0] col, input logic [63:0] wd, input logic [7:0] wm,
                         output int first);
        int r;
        wait_ready(200, r);
        check("issue_ready", req_ready, 1'b1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = {bk, row, col};
        req_wdata = wd;
        req_wmask = wm;
        @(negedge clk);
        req_valid = 1'b0;
        first     = cyc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        step(3);
        check("rst_cmd", cmd_bus, CMD_NOP);
        check("rst_ba", ba, 0);
        check("rst_addr", addr, 0);
        check("rst_dq_oe", dq_oe, 0);
        check("rst_dq_o", dq_o, 0);
        check("rst_dm", dm, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_ready", req_ready, 0);
        reset = 1'b0;
        step(1);
        check("ready_after_rst", req_ready, 1);

        // Write to a closed bank: ACT, WRITE 4 later, two data beats, ready 8 later
        issue(1'b1, 3'd2, 16'h0010, 10'h005, 64'h1122334455667788, 8'hFF, t);
        check("w_act_cmd", cmd_bus, CMD_ACT);
        check("w_act_row", addr, 16'h0010);
        check("w_act_ba", ba, 2);
        check("w_busy_ready", req_ready, 0);
        wait_cmd(CMD_WRITE, 10, at);
        check("w_write_at", at, t + 4);
        check("w_write_col", addr, 16'h0005);
        check("w_write_ba", ba, 2);
        check("w_dq_oe0", dq_oe, 1);
        check("w_dq_o0", dq_o, 64'h1122334455667788);
        check("w_dm0", dm, 8'h00);
        step(1);
        check("w_dq_oe1", dq_oe, 1);
        check("w_dq_o1", dq_o, 64'h1122334455667788);
        check("w_dm1", dm, 8'h00);
        step(1);
        check("w_dq_oe2", dq_oe, 0);
        check("w_dm2", dm, 8'h00);
        wait_ready(10, at);
        check("w_ready_at", at, t + 8);

        // Row-hit read: READ immediately, data CL+1 later
        issue(1'b0, 3'd2, 16'h0010, 10'h005, 64'h0, 8'h00, t);
        check("hit_read_cmd", cmd_bus, CMD_READ);
        wait_rdv(10, at);
        check("hit_rdv_at", at, t + 4);
        check("hit_rd_data", rd_data, 64'h1122334455667788);
        step(1);
        check("hit_rdv_pulse", rd_valid, 0);

        // Row-miss read: PRE, ACT, READ, data
        issue(1'b0, 3'd2, 16'h0020, 10'h005, 64'h0, 8'h00, t);
        check("miss_pre_cmd", cmd_bus, CMD_PRE);
        check("miss_pre_ba", ba, 2);
        wait_cmd(CMD_ACT, 10, at);
        check("miss_act_at", at, t + 4);
        check("miss_act_row", addr, 16'h0020);
        wait_cmd(CMD_READ, 10, at);
        check("miss_read_at", at, t + 8);
        wait_rdv(10, at);
        check("miss_rdv_at", at, t + 12);
        check("miss_rd_data", rd_data, 64'h0);

        // Masked writes on a hit row, then read back the merge
        issue(1'b1, 3'd2, 16'h0020, 10'h005, 64'h0102030405060708, 8'hFF, t);
        check("full_hit_write", cmd_bus, CMD_WRITE);
        issue(1'b1, 3'd2, 16'h0020, 10'h005, 64'hAABBCCDDEEFF0011, 8'h0F, t);
        check("mask_write_cmd", cmd_bus, CMD_WRITE);
        check("mask_dm0", dm, 8'hF0);
        check("mask_dq_o0", dq_o, 64'hAABBCCDDEEFF0011);
        step(1);
        check("mask_dm1", dm, 8'hF0);
        check("mask_dq_oe1", dq_oe, 1);
        issue(1'b1, 3'd2, 16'h0020, 10'h005, 64'hFFFFFFFFFFFFFFFF, 8'h00, t);
        check("nomask_write_cmd", cmd_bus, CMD_WRITE);
        check("nomask_dm", dm, 8'hFF);
        issue(1'b0, 3'd2, 16'h0020, 10'h005, 64'h0, 8'h00, t);
        check("merge_read_cmd", cmd_bus, CMD_READ);
        wait_rdv(10, at);
        check("merge_rd_data", rd_data, 64'h01020304EEFF0011);

        // Refresh with banks 0 and 5 open; counter origin is the reset-release cycle
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        rc = cyc;
        step(1);
        issue(1'b1, 3'd0, 16'h0001, 10'h000, 64'h55, 8'hFF, t);
        check("ref_open0_act", cmd_bus, CMD_ACT);
        issue(1'b0, 3'd5, 16'h0002, 10'h001, 64'h0, 8'h00, t);
        check("ref_open5_act", cmd_bus, CMD_ACT);
        wait_rdv(10, at);
        while (cyc < rc + 779) @(negedge clk);
        check("ref_ready_before", req_ready, 1);
        step(1);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = {3'd5, 16'h0002, 10'h001};
        check("ref_wins_ready", req_ready, 0);
        check("ref_wins_nop", cmd_bus, CMD_NOP);
        wait_cmd(CMD_PRE, 5, at);
        check("ref_pre0_at", at, rc + 781);
        check("ref_pre0_ba", ba, 0);
        step(1);
        wait_cmd(CMD_PRE, 10, at);
        check("ref_pre5_at", at, rc + 785);
        check("ref_pre5_ba", ba, 5);
        wait_cmd(CMD_REF, 10, at);
        check("ref_ref_at", at, rc + 789);
        check("ref_ref_ba", ba, 0);
        check("ref_ref_addr", addr, 0);
        wait_ready(20, at);
        check("ref_ready_at", at, rc + 799);
        @(negedge clk);
        req_valid = 1'b0;
        check("post_ref_act", cmd_bus, CMD_ACT);

        // Reset while in ACT_WAIT abandons the read
        step(1);
        reset = 1'b1;
        step(1);
        check("abort_cmd", cmd_bus, CMD_NOP);
        check("abort_ready", req_ready, 0);
        check("abort_rdv", rd_valid, 0);
        reset = 1'b0;
        step(1);
        check("abort_ready_after", req_ready, 1);
        n_rd = 0;
        n_rv = 0;
        for (int i = 0; i < 10; i++) begin
            if (cmd_bus == CMD_READ) n_rd++;
            if (rd_valid) n_rv++;
            step(1);
        end
        check("abort_no_read", n_rd, 0);
        check("abort_no_rdv", n_rv, 0);
        issue(1'b0, 3'd5, 16'h0002, 10'h001, 64'h0, 8'h00, t);
        check("abort_bank_closed", cmd_bus, CMD_ACT);
        wait_rdv(20, at);
        check("abort_readback_at", at, t + 8);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
